// File: rtl/crop_normalizer.sv
// crop_normalizer
//
// Sits behind the crop filter's output FIFO. Once armed by ap_start it waits
// for the crop filter to report completion, latches the window maximum, then
// drains the buffered crop one pixel at a time and scales each pixel to
//     q = floor(pix * (2^OUT_BIT_WIDTH - 1) / max)
// using a sequential restoring divider (one quotient bit per cycle). Results
// leave on an AXI-Stream master. Only one pixel is in flight at any time.
//
// Optional build macro:
//   NORM_ROUND_EN - adds floor(max/2) to the numerator, giving
//                   round-to-nearest instead of floor. Saturation is unchanged.
//
// Ports:
//   clk            clock
//   reset          synchronous, active-high reset (aborts any window)
//   ap_start       one-cycle pulse, arms the block for one crop window
//   crop_done      crop filter completion strobe (sampled only while waiting)
//   max_value      window maximum from the crop filter
//   s_axis_*       cropped pixel input (tvalid/tready/tdata)
//   m_axis_*       normalized pixel output (tvalid/tready/tdata/tlast)
//   ap_done        one-cycle pulse after the last output handshake
//   busy           high whenever the block is not idle

`timescale 1ns/1ps
`default_nettype none

module crop_normalizer #(
    parameter int PIXEL_BIT_WIDTH = 10,
    parameter int OUT_BIT_WIDTH   = 8,
    parameter int OUT_ROWS        = 10,
    parameter int OUT_COLS        = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ap_start,
    input  logic                       crop_done,
    input  logic [PIXEL_BIT_WIDTH-1:0] max_value,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic [PIXEL_BIT_WIDTH-1:0] s_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [OUT_BIT_WIDTH-1:0]   m_axis_tdata,
    output logic                       m_axis_tlast,
    output logic                       ap_done,
    output logic                       busy
);

    localparam int N  = OUT_ROWS * OUT_COLS;
    localparam int D  = PIXEL_BIT_WIDTH + OUT_BIT_WIDTH;
    localparam int CW = $clog2(N + 1);
    localparam int IW = $clog2(D + 1);
    localparam int PW = PIXEL_BIT_WIDTH;

    localparam logic [D-1:0]             QMAX_D    = D'((1 << OUT_BIT_WIDTH) - 1);
    localparam logic [OUT_BIT_WIDTH-1:0] QMAX_O    = '1;
    localparam logic [CW-1:0]            LAST_IDX  = CW'(N - 1);
    localparam logic [IW-1:0]            LAST_ITER = IW'(D - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_LATCH,
        ST_ACCEPT,
        ST_DIV,
        ST_ZERO,
        ST_OUT,
        ST_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [PW-1:0]            r_max;
    logic [PW-1:0]            r_pix;
    // Holds the numerator at the start of a division; quotient bits shift in
    // at the LSB as numerator bits shift out at the MSB, so after D steps it
    // holds the full quotient.
    logic [D-1:0]             r_num;
    logic [PW:0]              r_rem;
    logic [IW-1:0]            r_iter;
    logic [OUT_BIT_WIDTH-1:0] r_result;
    logic [CW-1:0]            r_count;

    // ------------------------------------------------------------------
    // Numerator formed at the input handshake
    // ------------------------------------------------------------------
    logic [D-1:0] w_num;
`ifdef NORM_ROUND_EN
    assign w_num = D'(s_axis_tdata) * QMAX_D + D'(r_max >> 1);
`else
    assign w_num = D'(s_axis_tdata) * QMAX_D;
`endif

    // ------------------------------------------------------------------
    // One restoring-division step. The shifted remainder is kept one bit
    // wider than the remainder so the subtraction's sign bit doubles as the
    // "does not fit" indication: the operands are both below 2^(PW+1), so a
    // set top bit of the difference means a borrow occurred.
    // ------------------------------------------------------------------
    logic [PW+1:0] w_shifted;
    logic [PW+1:0] w_diff;
    logic          w_qbit;
    logic [PW:0]   w_rem_next;
    logic [D-1:0]  w_quot_next;
    logic          w_sat;

    assign w_shifted   = {r_rem, r_num[D-1]};
    assign w_diff      = w_shifted - {2'b00, r_max};
    assign w_qbit      = ~w_diff[PW+1];
    assign w_rem_next  = w_qbit ? w_diff[PW:0] : w_shifted[PW:0];
    assign w_quot_next = {r_num[D-2:0], w_qbit};
    assign w_sat       = (w_quot_next > QMAX_D) || (r_pix > r_max);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        ap_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ap_start) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (crop_done) begin
                    w_state_next = ST_LATCH;
                end
            end
            ST_LATCH: begin
                // Max is sampled one cycle after crop_done so a final crop
                // write landing together with crop_done is included.
                w_state_next = ST_ACCEPT;
            end
            ST_ACCEPT: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid) begin
                    w_state_next = (r_max == '0) ? ST_ZERO : ST_DIV;
                end
            end
            ST_DIV: begin
                if (r_iter == LAST_ITER) begin
                    w_state_next = ST_OUT;
                end
            end
            ST_ZERO: begin
                w_state_next = ST_OUT;
            end
            ST_OUT: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = (r_count == LAST_IDX);
                if (m_axis_tready) begin
                    w_state_next = (r_count == LAST_IDX) ? ST_DONE : ST_ACCEPT;
                end
            end
            ST_DONE: begin
                ap_done      = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign busy         = (r_state != ST_IDLE);
    assign m_axis_tdata = r_result;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_max    <= '0;
            r_pix    <= '0;
            r_num    <= '0;
            r_rem    <= '0;
            r_iter   <= '0;
            r_result <= '0;
            r_count  <= '0;
        end else begin
            case (r_state)
                ST_LATCH: begin
                    r_max <= max_value;
                end
                ST_ACCEPT: begin
                    if (s_axis_tvalid) begin
                        r_pix  <= s_axis_tdata;
                        r_num  <= w_num;
                        r_rem  <= '0;
                        r_iter <= '0;
                    end
                end
                ST_DIV: begin
                    r_num  <= w_quot_next;
                    r_rem  <= w_rem_next;
                    r_iter <= r_iter + 1'b1;
                    if (r_iter == LAST_ITER) begin
                        r_result <= w_sat ? QMAX_O : w_quot_next[OUT_BIT_WIDTH-1:0];
                    end
                end
                ST_ZERO: begin
                    r_result <= '0;
                end
                ST_OUT: begin
                    if (m_axis_tready) begin
                        r_count <= r_count + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_count <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_crop_normalizer.sv
// tb_crop_normalizer
//
// Directed bench for crop_normalizer with default parameters (10-bit pixels,
// 8-bit output, 10x10 window). Inputs change and outputs are sampled on the
// falling clock edge. Builds with or without NORM_ROUND_EN.

`timescale 1ns/1ps

module tb_crop_normalizer;

    localparam int N   = 100;
    localparam int D   = 18;
    localparam int LAT = D + 1;

    logic       clk;
    logic       reset;
    logic       ap_start;
    logic       crop_done;
    logic [9:0] max_value;
    logic       s_axis_tvalid;
    logic       s_axis_tready;
    logic [9:0] s_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tlast;
    logic       ap_done;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;
    int out_idx  = 0;

    crop_normalizer dut (
        .clk           (clk),
        .reset         (reset),
        .ap_start      (ap_start),
        .crop_done     (crop_done),
        .max_value     (max_value),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .ap_done       (ap_done),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

`ifdef NORM_ROUND_EN
    localparam int EXP_512_1023 = 128;
    localparam int EXP_50_100   = 128;
    localparam int EXP_1_100    = 3;
`else
    localparam int EXP_512_1023 = 127;
    localparam int EXP_50_100   = 127;
    localparam int EXP_1_100    = 2;
`endif

    // Reference scaling for the bulk (non hand-computed) pixels.
    function automatic int model_q(input int pix, input int mx);
        int q;
        if (mx == 0) return 0;
`ifdef NORM_ROUND_EN
        q = (pix * 255 + mx / 2) / mx;
`else
        q = (pix * 255) / mx;
`endif
        if (q > 255 || pix > mx) q = 255;
        return q;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d required %0d", tag, obs, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".s_tready"}, s_axis_tready, 0);
        check({tag, ".m_tvalid"}, m_axis_tvalid, 0);
        check({tag, ".m_tdata"},  m_axis_tdata,  0);
        check({tag, ".m_tlast"},  m_axis_tlast,  0);
        check({tag, ".ap_done"},  ap_done,       0);
        check({tag, ".busy"},     busy,          0);
    endtask

    // Arm, report crop completion, and land in the accept state.
    task automatic start_window(input int mx);
        ap_start = 1'b1;
        tick();
        ap_start  = 1'b0;
        crop_done = 1'b1;
        max_value = 10'(mx);
        tick();
        crop_done = 1'b0;
        tick();
    endtask

    // Push one pixel, wait for its result, check it, optionally stall the
    // output for 'stall' cycles, then complete the output handshake.
    task automatic send_pixel(input int pix, input int exp_q, input int exp_lat, input int stall);
        int lat;
        s_axis_tdata  = 10'(pix);
        s_axis_tvalid = 1'b1;
        lat = 0;
        while (s_axis_tready !== 1'b1 && lat < 64) begin
            tick();
            lat++;
        end
        check($sformatf("s_tready[%0d]", out_idx), s_axis_tready, 1);
        tick();
        s_axis_tvalid = 1'b0;
        lat = 1;
        while (m_axis_tvalid !== 1'b1 && lat < 64) begin
            tick();
            lat++;
        end
        check($sformatf("latency[%0d]", out_idx), lat, exp_lat);
        check($sformatf("tdata[%0d] pix=%0d", out_idx, pix), m_axis_tdata, exp_q);
        check($sformatf("tlast[%0d]", out_idx), m_axis_tlast, (out_idx == N - 1) ? 1 : 0);
        if (stall > 0) begin
            m_axis_tready = 1'b0;
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 10'd777;
            for (int k = 0; k < stall; k++) begin
                tick();
                check($sformatf("stall_tvalid[%0d]", k), m_axis_tvalid, 1);
                check($sformatf("stall_tdata[%0d]", k), m_axis_tdata, exp_q);
                check($sformatf("stall_s_tready[%0d]", k), s_axis_tready, 0);
            end
            s_axis_tvalid = 1'b0;
            m_axis_tready = 1'b1;
        end
        tick();
        out_idx++;
        check($sformatf("ap_done_after[%0d]", out_idx - 1), ap_done, (out_idx == N) ? 1 : 0);
        check($sformatf("tvalid_drop[%0d]", out_idx - 1), m_axis_tvalid, 0);
        if (out_idx == N) begin
            out_idx = 0;
            tick();
            check("ap_done_pulse_end", ap_done, 0);
            check("busy_after_done", busy, 0);
        end
    endtask

    initial begin
        reset         = 1'b1;
        ap_start      = 1'b0;
        crop_done     = 1'b0;
        max_value     = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b1;

        // Reset state
        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        tick();
        check("idle_busy", busy, 0);

        // Window A: max=1023, hand-computed head then model-checked tail
        start_window(1023);
        check("armed_busy", busy, 1);
        send_pixel(1023, 255, LAT, 0);
        send_pixel(512, EXP_512_1023, LAT, 0);
        send_pixel(0, 0, LAT, 0);
        for (int i = 3; i < N; i++) begin
            send_pixel((i * 37) % 1024, model_q((i * 37) % 1024, 1023), LAT, 0);
        end

        // Window B: max=0, every output forced to zero on the short path
        start_window(0);
        for (int i = 0; i < N; i++) begin
            send_pixel((i * 53 + 7) % 1024, 0, 2, 0);
        end

        // Abort with reset while dividing pixel 37
        start_window(1023);
        for (int i = 0; i < 37; i++) begin
            send_pixel((i * 29) % 1024, model_q((i * 29) % 1024, 1023), LAT, 0);
        end
        s_axis_tdata  = 10'd600;
        s_axis_tvalid = 1'b1;
        check("p37_s_tready", s_axis_tready, 1);
        tick();
        s_axis_tvalid = 1'b0;
        repeat (4) tick();
        check("p37_busy_in_div", busy, 1);
        check("p37_no_tvalid", m_axis_tvalid, 0);
        reset = 1'b1;
        tick();
        check_reset_outputs("abort");
        reset   = 1'b0;
        out_idx = 0;
        repeat (3) tick();
        check("abort_no_done", ap_done, 0);
        check("abort_idle", busy, 0);

        // Window C: input offered before crop_done, ap_start while busy,
        // saturation, and an output stall
        ap_start = 1'b1;
        tick();
        ap_start      = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 10'd200;
        check("wait_busy", busy, 1);
        check("wait_s_tready", s_axis_tready, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("wait_s_tready[%0d]", k), s_axis_tready, 0);
        end
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        check("second_start_s_tready", s_axis_tready, 0);
        crop_done = 1'b1;
        max_value = 10'd100;
        tick();
        crop_done = 1'b0;
        check("latch_s_tready", s_axis_tready, 0);
        tick();
        check("accept_s_tready", s_axis_tready, 1);
        send_pixel(200, 255, LAT, 0);
        send_pixel(50, EXP_50_100, LAT, 0);
        send_pixel(100, 255, LAT, 0);
        send_pixel(99, 252, LAT, 0);
        send_pixel(1, EXP_1_100, LAT, 10);
        for (int i = 5; i < N; i++) begin
            send_pixel((i * 11) % 256, model_q((i * 11) % 256, 100), LAT, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/crop_normalizer.md
Name: crop_normalizer

Overview:
- Sits directly downstream of the crop filter's output FIFO.
- Waits for the crop filter to finish one crop window, then latches the window's maximum pixel value.
- Drains the buffered crop and scales each pixel to q = floor(pix*(2^OUT_BIT_WIDTH-1)/max), using a sequential restoring divider.
- Emits the normalized pixels on an AXI-Stream master to the inference stage.

Parameters:
PIXEL_BIT_WIDTH, 10, input pixel and max_value width
OUT_BIT_WIDTH, 8, normalized output pixel width
OUT_ROWS, 10, crop window rows
OUT_COLS, 10, crop window columns

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
ap_start  input  1  one-cycle pulse; arms the block for one crop window
crop_done  input  1  crop filter completion strobe (level, at least 1 cycle)
max_value  input  PIXEL_BIT_WIDTH  window maximum from crop filter
s_axis_tvalid  input  1  cropped pixel valid (from crop FIFO)
s_axis_tready  output  1  ready to accept cropped pixel
s_axis_tdata  input  PIXEL_BIT_WIDTH  cropped pixel
m_axis_tvalid  output  1  normalized pixel valid
m_axis_tready  input  1  downstream ready
m_axis_tdata  output  OUT_BIT_WIDTH  normalized pixel
m_axis_tlast  output  1  high with last pixel of window
ap_done  output  1  one-cycle pulse after last output handshake
busy  output  1  high in any state except IDLE

Behaviour:
- Reset values: s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, ap_done=0, busy=0. State=IDLE, counters=0.
- Reset asserted mid-operation aborts immediately. Any pending output is dropped; no ap_done is issued.
- Constants:
  - N = OUT_ROWS*OUT_COLS.
  - D = PIXEL_BIT_WIDTH+OUT_BIT_WIDTH divider iterations.
  - QMAX = 2^OUT_BIT_WIDTH-1.
- States:
  - IDLE: ap_start -> WAIT. Other inputs ignored; s_axis_tready=0.
  - WAIT: s_axis_tready=0. First cycle with crop_done=1 -> LATCH.
  - LATCH: register max_value, one cycle after crop_done is first seen. This covers a final crop write coincident with crop_done. -> ACCEPT.
  - ACCEPT: s_axis_tready=1. On handshake: register numerator = pix*QMAX (D bits), clear remainder. -> DIV. If latched max==0 -> ZERO instead of DIV.
  - DIV: one quotient bit per cycle, MSB first, exactly D cycles. Then saturate: q>QMAX or pix>max -> QMAX. -> OUT.
  - ZERO: result=0, one cycle. -> OUT.
  - OUT: m_axis_tvalid=1 with data stable until m_axis_tready.
    - On handshake: increment pixel count.
    - Count reaches N -> DONE; else -> ACCEPT.
  - DONE: ap_done=1 for one cycle. -> IDLE.
- Latency: input handshake in cycle t; m_axis_tvalid first high in cycle t+D+1 (t+2 for ZERO path).
- m_axis_tlast=1 exactly when the pixel being presented is index N-1.
- Not pipelined: one pixel in flight; s_axis_tready=0 outside ACCEPT.
- Pixel count width: $clog2(N+1). Wraps to 0 on DONE.
- ap_start while busy is ignored.
- crop_done while not in WAIT is ignored.
- Divider uses a (PIXEL_BIT_WIDTH+1)-bit remainder. Subtract-compare is against the zero-extended latched max.

Optional Feature:
NORM_ROUND_EN:
- Defined: numerator = pix*QMAX + floor(max/2), giving round-to-nearest. Saturation rule unchanged.
- Undefined: floor division as above.

Test Plan:
- ap_start, crop_done, max=1023; stream pix=1023, 512, 0 -> outputs 255, 127 (128 with NORM_ROUND_EN), 0. First output valid exactly 19 cycles after its input handshake.
- max=0, full 100-pixel window of arbitrary data -> 100 outputs all 0, tlast on the 100th, ap_done one cycle after the last handshake.
- max=100, pix=200 -> output 255 (saturation).
- m_axis_tready held low 10 cycles during OUT -> tvalid and tdata stable. s_axis_tready=0 throughout; no input consumed.
- Reset asserted in DIV on pixel 37 -> next cycle all outputs at reset values and busy=0. A new ap_start runs a full 100-pixel window correctly.
- ap_start then s_axis_tvalid=1 before crop_done -> s_axis_tready stays 0 until the cycle after LATCH. The second ap_start while busy has no effect.
